res_add_layer7: RTL

Residual-merge stage directly downstream of the layer-7 window/pooling wrapper. It captures the 2×2 average-pooled shortcut vector each time the wrapper asserts its pooled-output enable, and buffers it in a small FIFO. When the macro decoder delivers the matching convolution result, it adds a per-channel bias, saturates to `DATA_WIDTH`, and emits the layer-7 output vector. It also owns the per-channel bias table, loaded while the layer is in reload mode.

---
 rtl/layer_pkg.sv | 29 ++
 rtl/res_fifo.sv | 82 ++++++++
 rtl/res_add_layer7.sv | 131 +++++++++++++
 3 files changed

// File: rtl/layer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : layer_pkg
// Description : Shared definitions for the layer pipeline. Holds the data
//               width, the mode encodings and an 18-to-16 bit saturator.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package layer_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int SUM_WIDTH  = DATA_WIDTH + 2;

   localparam logic RELOAD    = 1'b0;
   localparam logic CALCULATE = 1'b1;

   // Clamp an 18-bit signed sum into the signed 16-bit range.
   function automatic logic signed [DATA_WIDTH-1:0] sat16(input logic signed [SUM_WIDTH-1:0] s);
      if (s > 18'sd32767) begin
         return 16'sh7FFF;
      end else if (s < -18'sd32768) begin
         return 16'sh8000;
      end else begin
         return s[DATA_WIDTH-1:0];
      end
   endfunction

endpackage : layer_pkg
`default_nettype wire

// File: rtl/res_fifo.sv
`default_nettype none
// ============================================================================
// Module      : res_fifo
// Description : Vector-wide synchronous FIFO for the residual path. Each entry
//               is one full channel vector. Pointers wrap naturally because
//               DEPTH is a power of two (at least 2).
// Ports       : clk, rst_n  - clock, async active-low reset
//               clr         - synchronous clear of pointers and count
//               push, din   - write one vector (caller guarantees room)
//               pop, dout   - dout shows the head entry; pop advances it
//               count       - entries held, 0..DEPTH
//               full, empty - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module res_fifo
   import layer_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int FM_DEPTH = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         push,
   input  logic                         pop,
   input  logic signed [DATA_WIDTH-1:0] din   [FM_DEPTH],
   output logic signed [DATA_WIDTH-1:0] dout  [FM_DEPTH],
   output logic [$clog2(DEPTH):0]       count,
   output logic                         full,
   output logic                         empty
);

   localparam int AW = $clog2(DEPTH);

   logic signed [DATA_WIDTH-1:0] mem_q [DEPTH][FM_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; its contents are only visible through valid pointers.
   always_ff @(posedge clk) begin
      if (push && !clr) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

endmodule : res_fifo
`default_nettype wire

// File: rtl/res_add_layer7.sv
`default_nettype none
// ============================================================================
// Module      : res_add_layer7
// Description : Layer-7 residual merge. Buffers pooled shortcut vectors,
//               adds them with the decoded conv vector and a per-channel bias,
//               saturates, and emits one output vector per conv_e.
// Ports       : clk, rst_n         - clock, async active-low reset
//               mode               - 0 reload parameters, 1 calculate
//               vs                 - frame sync, clears frame state
//               res_e, res_in      - residual vector push
//               conv_e, conv_in    - conv vector, triggers an output
//               bias_we/addr/data  - bias table write (reload mode only)
//               sum_e, sum_out     - output valid pulse and merged vector
//               frame_done         - pulses with the last output of a frame
//               err_underflow/overflow - sticky FIFO error flags
// Revision    : 1.0 - initial release
// ============================================================================
module res_add_layer7
   import layer_pkg::*;
#(
   parameter int FM_DEPTH      = 256,
   parameter int OUT_PER_FRAME = 49,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mode,
   input  logic                         vs,
   input  logic                         res_e,
   input  logic signed [DATA_WIDTH-1:0] res_in  [FM_DEPTH],
   input  logic                         conv_e,
   input  logic signed [DATA_WIDTH-1:0] conv_in [FM_DEPTH],
   input  logic                         bias_we,
   input  logic [7:0]                   bias_addr,
   input  logic signed [DATA_WIDTH-1:0] bias_data,
   output logic                         sum_e,
   output logic signed [DATA_WIDTH-1:0] sum_out [FM_DEPTH],
   output logic                         frame_done,
   output logic                         err_underflow,
   output logic                         err_overflow
);

   localparam int CW = $clog2(OUT_PER_FRAME + 1);

   logic signed [DATA_WIDTH-1:0] bias_q  [FM_DEPTH];
   logic signed [DATA_WIDTH-1:0] sum_q   [FM_DEPTH];
   logic signed [DATA_WIDTH-1:0] sum_d   [FM_DEPTH];
   logic signed [DATA_WIDTH-1:0] res_sel [FM_DEPTH];
   logic signed [DATA_WIDTH-1:0] fifo_dout [FM_DEPTH];
   logic [$clog2(FIFO_DEPTH):0]  fifo_count;
   logic                         fifo_full, fifo_empty;
   logic                         sum_e_q, frame_done_q, err_uf_q, err_of_q;
   logic [CW-1:0]                cnt_q;

   logic calc, res_acc, conv_acc, bypass, fifo_push, fifo_pop, last_out;

   // vs blocks all frame traffic for its cycle.
   assign calc     = (mode == CALCULATE) && !vs;
   assign res_acc  = calc && res_e;
   assign conv_acc = calc && conv_e;

   // An empty FIFO hands a same-cycle residual straight to the adder.
   assign bypass    = conv_acc && res_acc && fifo_empty;
   assign fifo_pop  = conv_acc && (fifo_count != '0);
   assign fifo_push = res_acc && !bypass && (!fifo_full || fifo_pop);
   assign last_out  = (cnt_q == CW'(OUT_PER_FRAME - 1));

   res_fifo #(
      .DEPTH    (FIFO_DEPTH),
      .FM_DEPTH (FM_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (vs),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (res_in),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      for (int i = 0; i < FM_DEPTH; i++) begin
         if (!fifo_empty)  res_sel[i] = fifo_dout[i];
         else if (bypass)  res_sel[i] = res_in[i];
         else              res_sel[i] = '0;
         sum_d[i] = sat16(SUM_WIDTH'(conv_in[i]) + SUM_WIDTH'(res_sel[i]) + SUM_WIDTH'(bias_q[i]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FM_DEPTH; i++) begin
            bias_q[i] <= '0;
            sum_q[i]  <= '0;
         end
         sum_e_q      <= 1'b0;
         frame_done_q <= 1'b0;
         err_uf_q     <= 1'b0;
         err_of_q     <= 1'b0;
         cnt_q        <= '0;
      end else begin
         // Address match against each index drops out-of-range writes.
         if (mode == RELOAD && bias_we) begin
            for (int i = 0; i < FM_DEPTH; i++) begin
               if (bias_addr == 8'(i)) bias_q[i] <= bias_data;
            end
         end

         sum_e_q      <= conv_acc;
         frame_done_q <= conv_acc && last_out;
         if (conv_acc) sum_q <= sum_d;

         if (vs)            cnt_q <= '0;
         else if (conv_acc) cnt_q <= last_out ? '0 : cnt_q + 1'b1;

         if (conv_acc && fifo_empty && !res_acc)         err_uf_q <= 1'b1;
         if (res_acc && fifo_full && !conv_acc)          err_of_q <= 1'b1;
      end
   end

   assign sum_e         = sum_e_q;
   assign sum_out       = sum_q;
   assign frame_done    = frame_done_q;
   assign err_underflow = err_uf_q;
   assign err_overflow  = err_of_q;

endmodule : res_add_layer7
`default_nettype wire
